// File: rtl/anubis_ctrl.sv
// Sequencer for a masked block-cipher core: key/plaintext intake, core load
// and run sequencing, ciphertext hand-off, and abort when mask randomness stalls.
module anubis_ctrl #(
  parameter int unsigned CORE_LAT = 16,
  parameter int unsigned LOAD_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid,
  input  logic [127:0] key_in,
  output logic         key_ready,
  input  logic         pt_valid,
  input  logic [127:0] pt_in,
  output logic         pt_ready,
  output logic         ct_valid,
  output logic [127:0] ct_out,
  input  logic         ct_ready,
  input  logic         rnd_ok,
  output logic         rnd_en,
  output logic         core_reset,
  output logic [1:0]   core_order,
  output logic [127:0] core_data_in,
  input  logic [127:0] core_data_out,
  output logic         err,
  output logic [15:0]  blk_cnt
);

  localparam int unsigned DW = 128;
  localparam int unsigned CW = 6;
  localparam int unsigned BW = 16;

  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_CYC - 1);
  localparam logic [CW-1:0] RUN_INIT  = CW'(CORE_LAT - 1);

  localparam logic [1:0] ORD_KEY  = 2'b00;
  localparam logic [1:0] ORD_PT   = 2'b01;
  localparam logic [1:0] ORD_ENC  = 2'b10;
  localparam logic [1:0] ORD_HOLD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CRST, S_LKEY, S_LPT, S_RUN, S_CAP, S_OUT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   key_q, key_d;
  logic [DW-1:0]   pt_q, pt_d;
  logic [DW-1:0]   ct_q, ct_d;
  logic [BW-1:0]   blk_q, blk_d;
  logic            key_loaded_q, key_loaded_d;
  logic            boot_q;
  logic            abort;
  logic            pt_ready_c;

  logic            key_ready_q, key_ready_d;
  logic            ct_valid_q, ct_valid_d;
  logic            rnd_en_q, rnd_en_d;
  logic            core_reset_q, core_reset_d;
  logic [1:0]      core_order_q, core_order_d;
  logic [DW-1:0]   core_data_q, core_data_d;
  logic            err_q, err_d;

  // Plaintext waits while a key is being offered in the same cycle.
  assign pt_ready_c = (state_q == S_IDLE) & key_loaded_q & rnd_ok & ~key_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    pt_d         = pt_q;
    ct_d         = ct_q;
    blk_d        = blk_q;
    abort        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (key_valid) begin
          key_d        = key_in;
          key_loaded_d = 1'b1;
        end else if (pt_valid && pt_ready_c) begin
          pt_d    = pt_in;
          state_d = S_CRST;
        end
      end
      S_CRST: begin
        state_d = S_LKEY;
        cnt_d   = LOAD_INIT;
      end
      S_LKEY: begin
        if (cnt_q == '0) begin
          state_d = S_LPT;
          cnt_d   = LOAD_INIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LPT: begin
        if (!rnd_ok) begin
          abort = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          cnt_d   = RUN_INIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RUN: begin
        if (!rnd_ok) begin
          abort = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_CAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_CAP: begin
        ct_d    = core_data_out;
        blk_d   = blk_q + BW'(1);
        state_d = S_OUT;
      end
      S_OUT: begin
        if (ct_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      pt_d    = '0;
    end

    // Outputs are registered from the next state so they align with state_q.
    key_ready_d  = (state_d == S_IDLE);
    ct_valid_d   = (state_d == S_OUT);
    rnd_en_d     = (state_d == S_LPT) || (state_d == S_RUN);
    core_reset_d = boot_q || (state_d == S_CRST) || abort;
    err_d        = abort;
    core_order_d = ORD_HOLD;
    core_data_d  = '0;
    unique case (state_d)
      S_LKEY: begin
        core_order_d = ORD_KEY;
        core_data_d  = key_q;
      end
      S_LPT: begin
        core_order_d = ORD_PT;
        core_data_d  = pt_q;
      end
      S_RUN:   core_order_d = ORD_ENC;
      default: core_order_d = ORD_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      pt_q         <= '0;
      ct_q         <= '0;
      blk_q        <= '0;
      boot_q       <= 1'b1;
      key_ready_q  <= 1'b1;
      ct_valid_q   <= 1'b0;
      rnd_en_q     <= 1'b0;
      core_reset_q <= 1'b1;
      core_order_q <= ORD_HOLD;
      core_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      pt_q         <= pt_d;
      ct_q         <= ct_d;
      blk_q        <= blk_d;
      boot_q       <= 1'b0;
      key_ready_q  <= key_ready_d;
      ct_valid_q   <= ct_valid_d;
      rnd_en_q     <= rnd_en_d;
      core_reset_q <= core_reset_d;
      core_order_q <= core_order_d;
      core_data_q  <= core_data_d;
      err_q        <= err_d;
    end
  end

  assign key_ready    = key_ready_q;
  assign pt_ready     = pt_ready_c;
  assign ct_valid     = ct_valid_q;
  assign ct_out       = ct_q;
  assign rnd_en       = rnd_en_q;
  assign core_reset   = core_reset_q;
  assign core_order   = core_order_q;
  assign core_data_in = core_data_q;
  assign err          = err_q;
  assign blk_cnt      = blk_q;

endmodule

// File: tb/tb_anubis_ctrl.sv
// Scoreboard bench for anubis_ctrl: accepted plaintexts queue expected results,
// an independent monitor checks every ciphertext the controller presents.
module tb_anubis_ctrl;

  localparam int LAT = 22;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid, pt_valid, ct_ready, rnd_ok;
  logic [127:0] key_in, pt_in, core_stub;
  logic         key_ready, pt_ready, ct_valid, rnd_en, core_reset, err;
  logic [127:0] ct_out, core_data_in;
  logic [1:0]   core_order;
  logic [15:0]  blk_cnt;

  anubis_ctrl dut (
    .clk(clk), .reset(rst_n),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .pt_valid(pt_valid), .pt_in(pt_in), .pt_ready(pt_ready),
    .ct_valid(ct_valid), .ct_out(ct_out), .ct_ready(ct_ready),
    .rnd_ok(rnd_ok), .rnd_en(rnd_en), .core_reset(core_reset),
    .core_order(core_order), .core_data_in(core_data_in),
    .core_data_out(core_stub), .err(err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    logic [15:0]  blk;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   exp_blk = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each accepted plaintext predicts one ciphertext, its block count and arrival cycle.
  always @(posedge clk) begin
    if (rst_n && pt_valid && pt_ready) begin
      exp_blk++;
      sb.push_back('{ct: core_stub, blk: 16'(exp_blk), cyc: cyc + 1 + LAT});
    end
  end

  logic         prev_valid = 1'b0, prev_ready = 1'b0;
  logic [127:0] prev_ct = '0;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (ct_valid && !prev_valid) begin
        if (sb.size() == 0) chk("ct_valid_unexpected", 128'(ct_valid), 128'(0));
        else chk("latency", 128'(cyc), 128'(sb[0].cyc));
      end
      if (ct_valid && prev_valid && !prev_ready) chk("ct_out_stable", ct_out, prev_ct);
      if (ct_valid && ct_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("ct_out", ct_out, e.ct);
        chk("blk_cnt", 128'(blk_cnt), 128'(e.blk));
      end
      prev_valid = ct_valid;
      prev_ready = ct_ready;
      prev_ct    = ct_out;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  function automatic logic [1:0] exp_order(input int k);
    if (k >= 2 && k <= 3) return 2'b00;
    if (k >= 4 && k <= 5) return 2'b01;
    if (k >= 6 && k <= 21) return 2'b10;
    return 2'b11;
  endfunction

  task automatic load_key(input logic [127:0] k);
    key_in = k;
    key_valid = 1'b1;
    #1 chk("key_ready", 128'(key_ready), 128'(1));
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic send_pt(input logic [127:0] p, input int max_wait, output int waited, output bit ok);
    pt_in = p;
    pt_valid = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (waited < max_wait && !ok) begin
      #1;
      if (pt_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (ok) @(negedge clk);
    pt_valid = 1'b0;
  endtask

  // Walks the block from the cycle after accept through CAP checking core-side outputs.
  task automatic check_seq(input logic [127:0] k, input logic [127:0] p);
    for (int i = 1; i <= 22; i++) begin
      #1;
      chk($sformatf("core_order_k%0d", i), 128'(core_order), 128'(exp_order(i)));
      if (i == 1) chk("core_reset_crst", 128'(core_reset), 128'(1));
      if (i == 2) chk("core_reset_after", 128'(core_reset), 128'(0));
      if (i == 2) chk("core_data_key", core_data_in, k);
      if (i == 4) chk("core_data_pt", core_data_in, p);
      if (i == 3) chk("rnd_en_lkey", 128'(rnd_en), 128'(0));
      if (i == 4) chk("rnd_en_lpt", 128'(rnd_en), 128'(1));
      if (i == 6) chk("core_data_run", core_data_in, 128'(0));
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ct_valid"}, 128'(ct_valid), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_rnd_en"}, 128'(rnd_en), 128'(0));
    chk({tag, "_core_reset"}, 128'(core_reset), 128'(1));
    chk({tag, "_core_order"}, 128'(core_order), 128'(2'b11));
    chk({tag, "_core_data"}, core_data_in, 128'(0));
    chk({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(0));
    chk({tag, "_ct_out"}, ct_out, 128'(0));
  endtask

  initial begin
    int w;
    bit ok;
    logic [127:0] key0, key1, key2;
    key0 = 128'h000102030405060708090a0b0c0d0e0f;
    key1 = 128'h11111111222222223333333344444444;
    key2 = 128'hfedcba9876543210f0e1d2c3b4a59687;

    rst_n = 1'b0;
    key_valid = 1'b0; pt_valid = 1'b0; ct_ready = 1'b1; rnd_ok = 1'b1;
    key_in = '0; pt_in = '0; core_stub = {16{8'haa}};
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("core_reset_boot", 128'(core_reset), 128'(1));
    @(negedge clk);
    #1 chk("core_reset_boot_end", 128'(core_reset), 128'(0));
    @(negedge clk);

    // Plaintext with no key loaded is refused and the core stays idle.
    send_pt('0, 5, w, ok);
    chk("nokey_refused", 128'(ok), 128'(0));
    chk("nokey_core_order", 128'(core_order), 128'(2'b11));
    chk("nokey_rnd_en", 128'(rnd_en), 128'(0));
    @(negedge clk);

    // Simultaneous key and plaintext: key wins, plaintext accepted next cycle.
    key_in = key0; key_valid = 1'b1;
    pt_in = '0; pt_valid = 1'b1;
    #1 chk("simul_pt_ready", 128'(pt_ready), 128'(0));
    @(negedge clk);
    key_valid = 1'b0;
    send_pt('0, 3, w, ok);
    chk("simul_accept_ok", 128'(ok), 128'(1));
    chk("simul_accept_wait", 128'(w), 128'(0));
    check_seq(key0, '0);
    repeat (3) @(negedge clk);
    #1 chk("blk1_idle_valid", 128'(ct_valid), 128'(0));
    chk("blk1_blk_cnt", 128'(blk_cnt), 128'(1));
    @(negedge clk);

    // Backpressure: ciphertext held, no new plaintext taken.
    core_stub = {16{8'h55}};
    ct_ready = 1'b0;
    send_pt(128'h0123456789abcdef0011223344556677, 3, w, ok);
    chk("bp_accept", 128'(ok), 128'(1));
    for (int i = 0; i < 40 && !ct_valid; i++) @(negedge clk);
    pt_in = 128'hdeadbeef; pt_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_ct_valid", 128'(ct_valid), 128'(1));
      chk("bp_pt_ready", 128'(pt_ready), 128'(0));
      @(negedge clk);
    end
    pt_valid = 1'b0;
    ct_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_release_valid", 128'(ct_valid), 128'(0));
    chk("bp_release_idle", 128'(key_ready), 128'(1));
    @(negedge clk);

    // Randomness stalls in RUN cycle 5: abort.
    core_stub = {16{8'h3c}};
    send_pt(128'h77, 3, w, ok);
    chk("abort_accept", 128'(ok), 128'(1));
    repeat (9) @(negedge clk);
    rnd_ok = 1'b0;
    void'(sb.pop_back());
    exp_blk--;
    @(negedge clk);
    rnd_ok = 1'b1;
    #1 chk("abort_err", 128'(err), 128'(1));
    chk("abort_core_reset", 128'(core_reset), 128'(1));
    chk("abort_idle", 128'(key_ready), 128'(1));
    chk("abort_rnd_en", 128'(rnd_en), 128'(0));
    chk("abort_blk_cnt", 128'(blk_cnt), 128'(2));
    chk("abort_ct_out", ct_out, {16{8'h55}});
    @(negedge clk);
    #1 chk("abort_err_once", 128'(err), 128'(0));
    chk("abort_core_reset_once", 128'(core_reset), 128'(0));
    repeat (25) @(negedge clk);

    // Asynchronous reset mid-RUN clears everything, including the key.
    send_pt(128'h99, 3, w, ok);
    chk("rst_accept", 128'(ok), 128'(1));
    repeat (7) @(negedge clk);
    #1 chk("rst_pre_rnd_en", 128'(rnd_en), 128'(1));
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_blk = 0;
    #1 check_reset_outputs("midrun");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_pt(128'h1, 4, w, ok);
    chk("rst_key_lost", 128'(ok), 128'(0));
    @(negedge clk);

    // A later key overwrites the earlier one.
    core_stub = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    load_key(key1);
    load_key(key2);
    send_pt(128'hcafe, 3, w, ok);
    chk("final_accept", 128'(ok), 128'(1));
    check_seq(key2, 128'hcafe);
    repeat (3) @(negedge clk);
    #1 chk("final_queue_empty", 128'(sb.size()), 128'(0));
    chk("final_blk_cnt", 128'(blk_cnt), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
